// File: rtl/rv_pkg.sv
// Shared RV32I fetch-side definitions: widths, PC step, base opcodes and the fetch state encoding.
package rv_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_e;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~32'h0000_0003;
  endfunction
endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Small synchronous FIFO with flush and occupancy count; head is read straight from storage registers.
module fetch_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full, pop_ok, push_ok;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign pop_ok   = pop && (count_q != '0);
  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign push_ok  = push && (!full || pop_ok);
  assign rd_valid = (count_q != '0);
  assign rd_data  = mem_q[rd_ptr_q];
  assign count    = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_ok) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always @(posedge clk) begin
    if (rst_n && !flush) assert (!(push && full && !pop_ok));
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// PC owner and credit-limited instruction prefetcher feeding decode; redirects flush the stream and
// convert every in-flight response into one to be dropped.
module instr_fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(FIFO_DEPTH);

  fetch_state_e          state_q, state_d;
  logic [XLEN-1:0]       pc_q, pc_d, pend_addr_q, pend_addr_d;
  logic                  pend_q, pend_d, pend_stale_q, pend_stale_d;
  logic [CNT_W-1:0]      out_q, out_d, drop_q, drop_d;
  logic [CNT_W-1:0]      buf_count, infl_count;
  logic                  run, credit_ok, req_hs, stale_now, rsp_drop, rsp_keep;
  logic                  infl_valid;
  logic [XLEN-1:0]       infl_pc;
  logic [ILEN+XLEN-1:0]  head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_IDLE: state_d = FETCH_RUN;
      FETCH_RUN:  state_d = FETCH_RUN;
      default:    state_d = FETCH_IDLE;
    endcase
  end

  always_comb begin
    run            = (state_q == FETCH_RUN);
    credit_ok      = ({1'b0, buf_count} + {1'b0, out_q} + {1'b0, drop_q}) < CREDITS;
    // A presented request is held with its original address even across redirects.
    imem_req_valid = pend_q | (run & credit_ok);
    imem_req_addr  = pend_q ? pend_addr_q : pc_q;
  end

  assign req_hs    = imem_req_valid & imem_req_ready;
  assign stale_now = (pend_q & pend_stale_q) | redirect_valid;
  assign rsp_drop  = imem_rsp_valid & (drop_q != '0);
  assign rsp_keep  = imem_rsp_valid & (drop_q == '0);

  always_comb begin
    pc_d         = pc_q;
    out_d        = out_q;
    drop_d       = drop_q;
    pend_d       = imem_req_valid & ~imem_req_ready;
    pend_addr_d  = imem_req_addr;
    pend_stale_d = pend_d & stale_now;
    if (redirect_valid) begin
      pc_d   = align_pc(redirect_pc);
      out_d  = '0;
      drop_d = drop_q + out_q + CNT_W'(req_hs) - CNT_W'(imem_rsp_valid);
    end else begin
      // A stale request was already replaced by the redirect target, so it must not advance the PC.
      if (req_hs && !stale_now) pc_d = pc_q + PC_STEP;
      out_d  = out_q + CNT_W'(req_hs & ~stale_now) - CNT_W'(rsp_keep);
      drop_d = drop_q + CNT_W'(req_hs & stale_now) - CNT_W'(rsp_drop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      pend_addr_q  <= RESET_PC;
      pend_q       <= 1'b0;
      pend_stale_q <= 1'b0;
      out_q        <= '0;
      drop_q       <= '0;
    end else begin
      pc_q         <= pc_d;
      pend_addr_q  <= pend_addr_d;
      pend_q       <= pend_d;
      pend_stale_q <= pend_stale_d;
      out_q        <= out_d;
      drop_q       <= drop_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(XLEN)) u_inflight_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (1'b0),
    .push     (req_hs),
    .wr_data  (imem_req_addr),
    .pop      (imem_rsp_valid),
    .rd_valid (infl_valid),
    .rd_data  (infl_pc),
    .count    (infl_count)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(ILEN + XLEN)) u_inst_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push     (rsp_keep & ~redirect_valid),
    .wr_data  ({imem_rsp_data, infl_pc}),
    .pop      (inst_valid & inst_ready),
    .rd_valid (inst_valid),
    .rd_data  (head),
    .count    (buf_count)
  );

  assign inst    = head[ILEN+XLEN-1:XLEN];
  assign inst_pc = head[XLEN-1:0];

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!imem_rsp_valid || infl_valid);
      assert (infl_count == out_q + drop_q);
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order instruction memory model (data = ~address).
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } req_t;
  typedef struct { logic [31:0] inst; logic [31:0] pc; } got_t;

  req_t        mq[$];
  got_t        got[$];
  logic [31:0] req_log[$];
  int          cyc = 0, checks = 0, errors = 0;
  int          lat_fix = 1;
  bit          lat_rand = 1'b0;
  int          ready_mode = 0;
  bit          prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_got(input int n, input int bound, input string tag);
    int k = 0;
    while (got.size() < n && k < bound) begin
      step();
      k++;
    end
    chk(tag, 32'(got.size() >= n), 32'd1);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    step(3);
    got.delete();
    req_log.delete();
    rst_n = 1'b1;
  endtask

  // Edge recorder: request log, memory scheduling, consumed instructions, request hold rule.
  initial forever begin
    int l;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      cyc = 0;
      prev_pend = 1'b0;
    end else begin
      cyc++;
      if (prev_pend) begin
        chk("req_hold_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("req_hold_addr", imem_req_addr, prev_addr);
      end
      if (imem_req_valid && imem_req_ready) begin
        l = lat_rand ? int'($urandom_range(4, 1)) : lat_fix;
        mq.push_back('{imem_req_addr, cyc + l - 1});
        req_log.push_back(imem_req_addr);
      end
      prev_pend = imem_req_valid && !imem_req_ready;
      prev_addr = imem_req_addr;
      if (inst_valid && inst_ready) got.push_back('{inst, inst_pc});
    end
  end

  // Memory responder: in order, one word per cycle once its latency has elapsed.
  initial forever begin
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    if (!rst_n) mq.delete();
    else if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ~mq[0].addr;
      void'(mq.pop_front());
    end
    if (ready_mode == 0)      imem_req_ready = 1'b1;
    else if (ready_mode == 1) imem_req_ready = 1'($urandom_range(1, 0));
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    inst_ready = 1'b1;

    // Reset state, then first fetches with 1-cycle memory
    step(2);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    got.delete();
    req_log.delete();
    rst_n = 1'b1;
    step();
    chk("c1_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("c1_req_addr", imem_req_addr, 32'h0);
    chk("c1_inst_valid", {31'b0, inst_valid}, 32'd0);
    step();
    chk("c2_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("c2_req_addr", imem_req_addr, 32'h4);
    chk("c2_inst_valid", {31'b0, inst_valid}, 32'd0);
    step();
    chk("c3_inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("c3_inst_pc", inst_pc, 32'h0);
    chk("c3_inst", inst, 32'hFFFF_FFFF);
    wait_got(4, 40, "seq_timeout");
    for (int i = 0; i < 4; i++) begin
      chk("seq_pc", got[i].pc, 32'(4 * i));
      chk("seq_inst", got[i].inst, ~32'(4 * i));
    end
    chk("seq_req0", req_log[0], 32'h0);
    chk("seq_req1", req_log[1], 32'h4);
    chk("seq_req2", req_log[2], 32'h8);

    // Decode stall: credits cap requests at two
    inst_ready = 1'b0;
    apply_reset();
    step(10);
    chk("stall_req_count", 32'(req_log.size()), 32'd2);
    chk("stall_req0", req_log[0], 32'h0);
    chk("stall_req1", req_log[1], 32'h4);
    chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("stall_inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("stall_inst_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    wait_got(3, 20, "stall_timeout");
    chk("stall_pc0", got[0].pc, 32'h0);
    chk("stall_pc1", got[1].pc, 32'h4);
    chk("stall_pc2", got[2].pc, 32'h8);

    // Random latency and random ready on both sides: stream must stay contiguous
    lat_rand = 1'b1;
    ready_mode = 1;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      inst_ready = 1'($urandom_range(1, 0));
      step();
    end
    inst_ready = 1'b1;
    ready_mode = 0;
    step(30);
    chk("rand_count", 32'(got.size() >= 30), 32'd1);
    for (int i = 0; i < got.size(); i++) begin
      chk("rand_pc", got[i].pc, 32'(4 * i));
      chk("rand_inst", got[i].inst, ~32'(4 * i));
    end
    lat_rand = 1'b0;

    // Redirect with two requests in flight (latency 3)
    lat_fix = 3;
    apply_reset();
    step(3);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    chk("redir_req_valid_c4", {31'b0, imem_req_valid}, 32'd0);
    chk("redir_inst_valid_c4", {31'b0, inst_valid}, 32'd0);
    step();
    chk("redir_req_valid_c5", {31'b0, imem_req_valid}, 32'd1);
    chk("redir_req_addr_c5", imem_req_addr, 32'h0000_0100);
    wait_got(1, 30, "redir_timeout");
    chk("redir_pc", got[0].pc, 32'h0000_0100);
    chk("redir_inst", got[0].inst, ~32'h0000_0100);

    // Redirect while a request at 0x10 is held unaccepted
    lat_fix = 1;
    ready_mode = 2;
    imem_req_ready = 1'b1;
    apply_reset();
    k = 0;
    while (!(imem_req_valid === 1'b1 && imem_req_addr === 32'h10) && k < 40) begin
      step();
      k++;
    end
    chk("hold_found", 32'(k < 40), 32'd1);
    imem_req_ready = 1'b0;
    req_log.delete();
    step();
    chk("hold_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("hold_addr", imem_req_addr, 32'h10);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    chk("hold_after_redir_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("hold_after_redir_addr", imem_req_addr, 32'h10);
    got.delete();
    k = 0;
    while (req_log.size() < 2 && k < 20) begin
      step();
      k++;
    end
    chk("hold_req_timeout", 32'(req_log.size() >= 2), 32'd1);
    chk("hold_req0", req_log[0], 32'h10);
    chk("hold_req1", req_log[1], 32'h200);
    wait_got(1, 30, "hold_got_timeout");
    chk("hold_pc", got[0].pc, 32'h200);
    chk("hold_inst", got[0].inst, ~32'h200);

    // PC wrap at the top of the address space
    ready_mode = 0;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    req_log.delete();
    got.delete();
    wait_got(3, 40, "wrap_timeout");
    chk("wrap_req0", req_log[0], 32'hFFFF_FFF8);
    chk("wrap_req1", req_log[1], 32'hFFFF_FFFC);
    chk("wrap_req2", req_log[2], 32'h0000_0000);
    chk("wrap_pc0", got[0].pc, 32'hFFFF_FFF8);
    chk("wrap_pc1", got[1].pc, 32'hFFFF_FFFC);
    chk("wrap_pc2", got[2].pc, 32'h0000_0000);
    chk("wrap_inst2", got[2].inst, 32'hFFFF_FFFF);

    // Asynchronous reset between clock edges
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("arst_req_addr", imem_req_addr, 32'h0);
    chk("arst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("arst_inst", inst, 32'h0);
    chk("arst_inst_pc", inst_pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
